// File: rtl/i2c_seq_pkg.sv
// Shared types and the constant register-write table for the I2C power-up
// sequencer (codec slave 7'd52).
//   seq_cmd_t   : one table entry {reg_addr, data, post-delay in 100 kHz ticks}
//   seq_state_t : sequencer FSM states
//   seq_table() : idx -> entry lookup; indices beyond the table return zero
package i2c_seq_pkg;

  localparam int unsigned SEQ_DELAY_W = 8;
  localparam int unsigned SEQ_IDX_W   = 4;

  typedef struct packed {
    logic [7:0]             reg_addr;
    logic [7:0]             data;
    logic [SEQ_DELAY_W-1:0] delay;
  } seq_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    GAP,
    DONE,
    ERROR
  } seq_state_t;

  // Codec bring-up: soft reset (needs 100 us to settle), then three config writes.
  function automatic seq_cmd_t seq_table(input logic [SEQ_IDX_W-1:0] idx);
    seq_cmd_t e;
    e = '0;
    case (idx)
      4'd0:    e = '{reg_addr: 8'h1E, data: 8'h00, delay: SEQ_DELAY_W'(10)};
      4'd1:    e = '{reg_addr: 8'h0C, data: 8'h00, delay: SEQ_DELAY_W'(0)};
      4'd2:    e = '{reg_addr: 8'h0E, data: 8'h02, delay: SEQ_DELAY_W'(0)};
      4'd3:    e = '{reg_addr: 8'h12, data: 8'h01, delay: SEQ_DELAY_W'(0)};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/i2c_seq_rom.sv
// Combinational table lookup for the init sequencer.
//   idx     : entry index
//   entry_c : table entry; all-zero for idx >= NUM_CMDS
module i2c_seq_rom
  import i2c_seq_pkg::*;
#(
  parameter int unsigned NUM_CMDS = 4
) (
  input  logic [SEQ_IDX_W-1:0] idx,
  output seq_cmd_t             entry_c
);

  always_comb begin
    entry_c = '0;
    if ({1'b0, idx} < 5'(NUM_CMDS)) begin
      entry_c = seq_table(idx);
    end
  end

endmodule

// File: rtl/i2c_init_seq.sv
// Power-up register-write sequencer feeding the I2C master one write at a time.
// Walks the constant table, offers each entry on a valid/ready command port,
// waits for the master response, then waits the entry's post-delay (counted
// in strobe_100kHz ticks) before the next entry. Flags done or error.
//
// Optional build macro I2C_SEQ_RETRY_EN: a NACKed entry is retried up to
// MAX_RETRY extra times, each after a fixed 10-tick gap, before flagging error.
//
// Ports:
//   clk_10MHz, areset_n       : clock, async active-low reset
//   strobe_100kHz             : one-cycle tick every 100 clocks
//   start                     : pulse; (re)starts the sequence from entry 0
//   cmd_valid/cmd_ready       : command handshake to the master
//   cmd_reg_addr, cmd_data    : command payload, stable while cmd_valid
//   rsp_valid, rsp_nack       : master response pulse and NACK flag
//   busy                      : sequence in progress
//   done, error               : sticky completion / failure flags
//   err_idx                   : index of the failing entry
module i2c_init_seq
  import i2c_seq_pkg::*;
#(
  parameter int unsigned NUM_CMDS = 4,
  parameter int unsigned DELAY_W  = SEQ_DELAY_W
`ifdef I2C_SEQ_RETRY_EN
  ,
  parameter int unsigned MAX_RETRY = 2
`endif
) (
  input  logic       clk_10MHz,
  input  logic       areset_n,
  input  logic       strobe_100kHz,
  input  logic       start,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_reg_addr,
  output logic [7:0] cmd_data,
  input  logic       rsp_valid,
  input  logic       rsp_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] err_idx
);

  localparam logic [SEQ_IDX_W-1:0] LAST_IDX = SEQ_IDX_W'(NUM_CMDS - 1);

`ifdef I2C_SEQ_RETRY_EN
  localparam int unsigned RETRY_W         = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int unsigned RETRY_GAP_TICKS = 10;
`endif

  seq_state_t           state_q, state_d;
  logic [SEQ_IDX_W-1:0] idx_q, idx_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [7:0]           cmd_reg_addr_q, cmd_reg_addr_d;
  logic [7:0]           cmd_data_q, cmd_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [3:0]           err_idx_q, err_idx_d;
`ifdef I2C_SEQ_RETRY_EN
  logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
  logic                 retry_pend_q, retry_pend_d;
`endif

  logic [SEQ_IDX_W-1:0] rom_idx_c;
  seq_cmd_t             rom_entry_c;

  // ROM address: the entry about to be loaded into the command registers, or
  // the current entry while waiting for its response (for its post-delay).
  always_comb begin
    rom_idx_c = idx_q;
    case (state_q)
      IDLE, DONE, ERROR: rom_idx_c = '0;
      GAP:               rom_idx_c = idx_q + SEQ_IDX_W'(1);
      default:           ;
    endcase
`ifdef I2C_SEQ_RETRY_EN
    if (state_q == GAP && retry_pend_q) begin
      rom_idx_c = idx_q;
    end
`endif
  end

  i2c_seq_rom #(
    .NUM_CMDS (NUM_CMDS)
  ) u_rom (
    .idx     (rom_idx_c),
    .entry_c (rom_entry_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    delay_d        = delay_q;
    cmd_reg_addr_d = cmd_reg_addr_q;
    cmd_data_d     = cmd_data_q;
    err_idx_d      = err_idx_q;
`ifdef I2C_SEQ_RETRY_EN
    retry_cnt_d    = retry_cnt_q;
    retry_pend_d   = retry_pend_q;
`endif

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d        = ISSUE;
          idx_d          = '0;
          err_idx_d      = '0;
          cmd_reg_addr_d = rom_entry_c.reg_addr;
          cmd_data_d     = rom_entry_c.data;
`ifdef I2C_SEQ_RETRY_EN
          retry_cnt_d    = '0;
          retry_pend_d   = 1'b0;
`endif
        end
      end

      ISSUE: begin
        if (cmd_valid_q && cmd_ready) begin
          state_d = WAIT_RSP;
        end
      end

      WAIT_RSP: begin
        if (rsp_valid) begin
          if (!rsp_nack) begin
            delay_d = DELAY_W'(rom_entry_c.delay);
            state_d = GAP;
`ifdef I2C_SEQ_RETRY_EN
            retry_cnt_d = '0;
`endif
          end
`ifdef I2C_SEQ_RETRY_EN
          else if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
            retry_cnt_d  = retry_cnt_q + RETRY_W'(1);
            retry_pend_d = 1'b1;
            delay_d      = DELAY_W'(RETRY_GAP_TICKS);
            state_d      = GAP;
          end
`endif
          else begin
            state_d   = ERROR;
            err_idx_d = 4'(idx_q);
          end
        end
      end

      GAP: begin
        // Counter only moves while nonzero, so it saturates at 0.
        if (delay_q != '0) begin
          if (strobe_100kHz) begin
            delay_d = delay_q - DELAY_W'(1);
          end
        end
`ifdef I2C_SEQ_RETRY_EN
        else if (retry_pend_q) begin
          retry_pend_d   = 1'b0;
          state_d        = ISSUE;
          cmd_reg_addr_d = rom_entry_c.reg_addr;
          cmd_data_d     = rom_entry_c.data;
        end
`endif
        else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d          = idx_q + SEQ_IDX_W'(1);
          state_d        = ISSUE;
          cmd_reg_addr_d = rom_entry_c.reg_addr;
          cmd_data_d     = rom_entry_c.data;
        end
      end

      default: state_d = IDLE;
    endcase

    cmd_valid_d = (state_d == ISSUE);
    busy_d      = (state_d == ISSUE) || (state_d == WAIT_RSP) || (state_d == GAP);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERROR);
  end

  always_ff @(posedge clk_10MHz or negedge areset_n) begin
    if (!areset_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      delay_q        <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_reg_addr_q <= '0;
      cmd_data_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      err_idx_q      <= '0;
`ifdef I2C_SEQ_RETRY_EN
      retry_cnt_q    <= '0;
      retry_pend_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      delay_q        <= delay_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_reg_addr_q <= cmd_reg_addr_d;
      cmd_data_q     <= cmd_data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      err_idx_q      <= err_idx_d;
`ifdef I2C_SEQ_RETRY_EN
      retry_cnt_q    <= retry_cnt_d;
      retry_pend_q   <= retry_pend_d;
`endif
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_reg_addr = cmd_reg_addr_q;
  assign cmd_data     = cmd_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_idx      = err_idx_q;

endmodule

// File: tb/tb_i2c_init_seq.sv
// Directed bench for i2c_init_seq: I2C master model (ACK/NACK after a fixed
// latency), 100 kHz strobe generator and handshake log, with expected values
// written out by hand from the codec table.
module tb_i2c_init_seq;

  localparam int RSP_LAT    = 30;
  localparam int STROBE_DIV = 100;
  localparam int BUDGET     = 20000;
  localparam int LOG_N      = 128;

  logic       clk_10MHz     = 1'b0;
  logic       areset_n      = 1'b0;
  logic       strobe_100kHz = 1'b0;
  logic       start         = 1'b0;
  logic       cmd_ready     = 1'b0;
  logic       rsp_valid     = 1'b0;
  logic       rsp_nack      = 1'b0;
  logic       cmd_valid;
  logic [7:0] cmd_reg_addr;
  logic [7:0] cmd_data;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] err_idx;

  i2c_init_seq dut (
    .clk_10MHz     (clk_10MHz),
    .areset_n      (areset_n),
    .strobe_100kHz (strobe_100kHz),
    .start         (start),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_reg_addr  (cmd_reg_addr),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_nack      (rsp_nack),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_idx       (err_idx)
  );

  always #5 clk_10MHz = ~clk_10MHz;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus model state (written only by the model process)
  logic [7:0] log_addr   [LOG_N];
  logic [7:0] log_data   [LOG_N];
  int         hs_strobe  [LOG_N];
  int         ack_strobe [LOG_N];
  int         n_hs         = 0;
  int         n_ack        = 0;
  int         rsp_timer    = 0;
  int         div          = 0;
  int         strobe_total = 0;
  int         spur_ack     = 0;
  int         nack_used    = 0;
  logic [7:0] cur_addr     = 8'h00;
  // Model controls (written only by the main sequence)
  int         spur_req     = 0;
  int         nack_quota   = 0;
  logic [7:0] nack_addr    = 8'h00;

  // Runs just after each falling edge, so everything it drives is stable for
  // the next rising edge and the handshake it logs completes on that edge.
  always begin
    @(negedge clk_10MHz);
    #1;
    if (!areset_n) begin
      rsp_timer = 0;
    end else if (cmd_valid && cmd_ready) begin
      if (n_hs < LOG_N) begin
        log_addr[n_hs]  = cmd_reg_addr;
        log_data[n_hs]  = cmd_data;
        hs_strobe[n_hs] = strobe_total;
      end
      cur_addr  = cmd_reg_addr;
      n_hs++;
      rsp_timer = RSP_LAT;
    end
    rsp_valid     = 1'b0;
    rsp_nack      = 1'b0;
    strobe_100kHz = 1'b0;
    div++;
    if (div == STROBE_DIV) begin
      div           = 0;
      strobe_100kHz = 1'b1;
      strobe_total++;
    end
    if (rsp_timer > 0) begin
      rsp_timer--;
      if (rsp_timer == 0) begin
        rsp_valid = 1'b1;
        if (cur_addr == nack_addr && nack_used < nack_quota) begin
          rsp_nack = 1'b1;
          nack_used++;
        end else begin
          if (n_ack < LOG_N) ack_strobe[n_ack] = strobe_total;
          n_ack++;
        end
      end
    end else if (spur_req != spur_ack) begin
      rsp_valid = 1'b1;
      rsp_nack  = 1'b1;
      spur_ack++;
    end
  end

  logic [7:0] exp_addr [4];
  logic [7:0] exp_data [4];
  int hs0;
  int ack0;

  task automatic mark();
    hs0  = n_hs;
    ack0 = n_ack;
  endtask

  task automatic pulse_start();
    @(negedge clk_10MHz);
    start = 1'b1;
    @(negedge clk_10MHz);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(done || error) && n < BUDGET) begin
      @(negedge clk_10MHz);
      n++;
    end
    check({tag, "_finished"}, 32'(done || error), 32'd1);
  endtask

  task automatic wait_hs(input string tag, input int target);
    int n;
    n = 0;
    while (n_hs < target && n < BUDGET) begin
      @(negedge clk_10MHz);
      n++;
    end
    check({tag, "_hs_reached"}, 32'(n_hs >= target), 32'd1);
  endtask

  task automatic wait_ack(input string tag, input int target);
    int n;
    n = 0;
    while (n_ack < target && n < BUDGET) begin
      @(negedge clk_10MHz);
      n++;
    end
    check({tag, "_ack_reached"}, 32'(n_ack >= target), 32'd1);
  endtask

  // Full clean sequence since the last mark(): four writes in table order.
  task automatic check_seq(input string tag);
    check({tag, "_hs_count"}, 32'(n_hs - hs0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(log_addr[hs0 + i]), 32'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), 32'(log_data[hs0 + i]), 32'(exp_data[i]));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_error"},     32'(error),     32'd0);
    check({tag, "_err_idx"},   32'(err_idx),   32'd0);
    check({tag, "_reg_addr"},  32'(cmd_reg_addr), 32'd0);
    check({tag, "_data"},      32'(cmd_data),  32'd0);
  endtask

  initial begin
    bit stable;
    exp_addr[0] = 8'h1E; exp_data[0] = 8'h00;
    exp_addr[1] = 8'h0C; exp_data[1] = 8'h00;
    exp_addr[2] = 8'h0E; exp_data[2] = 8'h02;
    exp_addr[3] = 8'h12; exp_data[3] = 8'h01;

    // Reset state
    areset_n = 1'b0;
    repeat (3) @(negedge clk_10MHz);
    check_idle_outputs("rst");
    areset_n = 1'b1;

    // T1: normal run, ready always high, ACK after ~30 cycles
    cmd_ready = 1'b1;
    mark();
    @(negedge clk_10MHz);
    start = 1'b1;
    check("t1_valid_before_start", 32'(cmd_valid), 32'd0);
    @(negedge clk_10MHz);
    start = 1'b0;
    check("t1_valid_one_cycle", 32'(cmd_valid), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_first_addr", 32'(cmd_reg_addr), 32'h1E);
    wait_end("t1");
    check_seq("t1");
    check("t1_gap_strobes", 32'(hs_strobe[hs0 + 1] - ack_strobe[ack0]), 32'd10);
    check("t1_done",  32'(done),  32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_error", 32'(error), 32'd0);

    // T2: ready held low 50 cycles in ISSUE
    cmd_ready = 1'b0;
    mark();
    pulse_start();
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk_10MHz);
      if (!(cmd_valid === 1'b1 && cmd_reg_addr === 8'h1E && cmd_data === 8'h00)) stable = 1'b0;
    end
    check("t2_held_stable", 32'(stable), 32'd1);
    check("t2_no_hs_while_low", 32'(n_hs - hs0), 32'd0);
    cmd_ready = 1'b1;
    wait_end("t2");
    check_seq("t2");
    check("t2_done", 32'(done), 32'd1);

`ifdef I2C_SEQ_RETRY_EN
    // T3a: two NACKs on entry 1, then ACK
    nack_addr  = 8'h0C;
    nack_quota = nack_used + 2;
    mark();
    pulse_start();
    wait_end("t3a");
    check("t3a_hs_count", 32'(n_hs - hs0), 32'd6);
    check("t3a_addr0", 32'(log_addr[hs0 + 0]), 32'h1E);
    check("t3a_addr1", 32'(log_addr[hs0 + 1]), 32'h0C);
    check("t3a_addr2", 32'(log_addr[hs0 + 2]), 32'h0C);
    check("t3a_addr3", 32'(log_addr[hs0 + 3]), 32'h0C);
    check("t3a_addr4", 32'(log_addr[hs0 + 4]), 32'h0E);
    check("t3a_addr5", 32'(log_addr[hs0 + 5]), 32'h12);
    check("t3a_done",  32'(done),  32'd1);
    check("t3a_error", 32'(error), 32'd0);

    // T3b: three NACKs on entry 1 exhaust the retries
    nack_quota = nack_used + 3;
    mark();
    pulse_start();
    wait_end("t3b");
    check("t3b_error",   32'(error),   32'd1);
    check("t3b_err_idx", 32'(err_idx), 32'd1);
    check("t3b_done",    32'(done),    32'd0);
    check("t3b_hs_count", 32'(n_hs - hs0), 32'd4);
`else
    // T3: NACK on entry 2 is fatal
    nack_addr  = 8'h0E;
    nack_quota = nack_used + 1;
    mark();
    pulse_start();
    wait_end("t3");
    check("t3_error",   32'(error),   32'd1);
    check("t3_err_idx", 32'(err_idx), 32'd2);
    check("t3_done",    32'(done),    32'd0);
    check("t3_busy",    32'(busy),    32'd0);
    check("t3_hs_count", 32'(n_hs - hs0), 32'd3);
    repeat (200) @(negedge clk_10MHz);
    check("t3_no_4th_cmd", 32'(n_hs - hs0), 32'd3);
    check("t3_error_sticky", 32'(error), 32'd1);
`endif

    // T4: reset while waiting for the response of entry 1
    nack_quota = nack_used;
    mark();
    pulse_start();
    check("t4_error_cleared", 32'(error), 32'd0);
    wait_hs("t4", hs0 + 2);
    repeat (5) @(negedge clk_10MHz);
    #2;
    areset_n = 1'b0;
    #1;
    check_idle_outputs("t4_rst");
    repeat (40) @(negedge clk_10MHz);
    check("t4_no_more_cmds", 32'(n_hs - hs0), 32'd2);
    check("t4_valid_low", 32'(cmd_valid), 32'd0);
    areset_n = 1'b1;
    @(negedge clk_10MHz);
    mark();
    pulse_start();
    wait_end("t4b");
    check_seq("t4b");
    check("t4b_done", 32'(done), 32'd1);

    // T5: start while busy and a spurious NACK response in GAP are ignored
    mark();
    pulse_start();
    wait_hs("t5", hs0 + 1);
    repeat (3) @(negedge clk_10MHz);
    check("t5_busy_at_restart", 32'(busy), 32'd1);
    pulse_start();
    wait_ack("t5", ack0 + 1);
    repeat (100) @(negedge clk_10MHz);
    spur_req++;
    pulse_start();
    wait_end("t5");
    check_seq("t5");
    check("t5_gap_strobes", 32'(hs_strobe[hs0 + 1] - ack_strobe[ack0]), 32'd10);
    check("t5_done",  32'(done),  32'd1);
    check("t5_error", 32'(error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
